// File: rtl/mc_latch_pkg.sv
// Purpose : shared write-mode encoding and constants for the MC14500B addressable latch family.
// Latency : n/a (types and constants only).
// Backpressure: n/a; stb is a fire-and-forget strobe with no ready/credit return.
//
// Contents:
//   mc_mode_t   - 2-bit write mode; all four codes are defined, there is no illegal mode.
//   SYNC_STAGES - depth of the optional strobe synchroniser in mc_edge_det.
//   to_mode()   - casts a raw 2-bit bus value onto mc_mode_t.
package mc_latch_pkg;

    typedef enum logic [1:0] {
        MODE_LATCH = 2'b00,  // r_q[a] <= dat, other bits hold
        MODE_DEMUX = 2'b01,  // r_q <= 0 except r_q[a] <= dat
        MODE_PULSE = 2'b10,  // self-timed one-shot on r_q[a]
        MODE_CLEAR = 2'b11   // r_q <= 0
    } mc_mode_t;

    localparam int SYNC_STAGES = 2;

    function automatic mc_mode_t to_mode(input logic [1:0] raw);
        return mc_mode_t'(raw);
    endfunction

endpackage

// File: rtl/mc_edge_det.sv
// Purpose : rising-edge detector for a write strobe, with an optional 2-flop synchroniser and matching data delay.
// Latency : rise is asserted combinationally in the cycle stb is first seen high (plus 2 cycles when MC_ADDR_LATCH_SYNC_EN is defined).
// Backpressure: none; a level held high yields exactly one rise pulse.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   stb  - raw strobe
//   din  - sideband data sampled alongside the strobe
//   rise - one-cycle pulse on a strobe rising edge
//   dout - din delayed to line up with rise
// Config macro: MC_ADDR_LATCH_SYNC_EN selects the synchronised strobe path.
module mc_edge_det
    import mc_latch_pkg::*;
#(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stb,
    input  logic [DW-1:0] din,
    output logic          rise,
    output logic [DW-1:0] dout
);

    logic stb_s;     // strobe as seen by the edge detector
    logic stb_hist;  // strobe value from the previous cycle

`ifdef MC_ADDR_LATCH_SYNC_EN
    logic [SYNC_STAGES-1:0] stb_sync;
    logic [DW-1:0]          din_d1;
    logic [DW-1:0]          din_d2;

    // Data follows the same two-stage path so it arrives with the strobe it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stb_sync <= '0;
            din_d1   <= '0;
            din_d2   <= '0;
        end else begin
            stb_sync <= {stb_sync[SYNC_STAGES-2:0], stb};
            din_d1   <= din;
            din_d2   <= din_d1;
        end
    end

    assign stb_s = stb_sync[SYNC_STAGES-1];
    assign dout  = din_d2;
`else
    assign stb_s = stb;
    assign dout  = din;
`endif

    // History resets high so a strobe already high when reset releases is not
    // mistaken for a fresh edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stb_hist <= 1'b1;
        end else begin
            stb_hist <= stb_s;
        end
    end

    assign rise = stb_s & ~stb_hist;

endmodule

// File: rtl/mc_addr_latch.sv
// Purpose : 2**AW-bit addressable output latch with latch / demux / one-shot pulse / clear write modes.
// Latency : command visible on q one cycle after the strobe edge (three with MC_ADDR_LATCH_SYNC_EN).
// Backpressure: none; commands are always accepted, collisions with a running pulse are resolved in place.
//
// Ports:
//   clk  - system clock         rst  - asynchronous active-low reset
//   dat  - data bit to write    stb  - write strobe, command on its rising edge
//   mode - write mode (mc_mode_t), sampled with stb
//   a    - bit address          oe   - active-low output enable
//   q    - latched outputs, high-Z while oe=1
//   busy - pulse in progress, always driven
// Config macro: MC_ADDR_LATCH_SYNC_EN adds a strobe synchroniser in front of edge detection.
module mc_addr_latch
    import mc_latch_pkg::*;
#(
    parameter int AW        = 3,
    parameter int PULSE_LEN = 4,
    parameter int CW        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dat,
    input  logic              stb,
    input  logic [1:0]        mode,
    input  logic [AW-1:0]     a,
    input  logic              oe,
    output logic [2**AW-1:0]  q,
    output logic              busy
);

    localparam int             WIDTH      = 2**AW;
    localparam int             CMD_W      = AW + 3;
    localparam logic [CW-1:0]  PULSE_INIT = CW'(PULSE_LEN);
    localparam logic [CW-1:0]  CNT_LAST   = CW'(1);

    if (PULSE_LEN < 1 || PULSE_LEN > (2**CW) - 1) begin : g_bad_pulse_len
        $error("mc_addr_latch: PULSE_LEN out of range for CW");
    end

    // ------------------------------------------------------------------
    // Strobe edge detection; command fields ride alongside the strobe.
    // ------------------------------------------------------------------
    logic             cmd_vld;
    logic [CMD_W-1:0] cmd_raw;
    logic [CMD_W-1:0] cmd_dat_bus;
    mc_mode_t         cmd_mode;
    logic             cmd_dat;
    logic [AW-1:0]    cmd_a;

    assign cmd_raw = {mode, dat, a};

    mc_edge_det #(
        .DW (CMD_W)
    ) u_edge_det (
        .clk  (clk),
        .rst  (rst),
        .stb  (stb),
        .din  (cmd_raw),
        .rise (cmd_vld),
        .dout (cmd_dat_bus)
    );

    assign cmd_mode = to_mode(cmd_dat_bus[CMD_W-1 -: 2]);
    assign cmd_dat  = cmd_dat_bus[AW];
    assign cmd_a    = cmd_dat_bus[AW-1:0];

    // ------------------------------------------------------------------
    // Latch and pulse state
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_q,     q_nxt;
    logic             busy_r,  busy_nxt;
    logic [CW-1:0]    cnt_r,   cnt_nxt;
    logic [AW-1:0]    paddr_r, paddr_nxt;
    logic             expire;

    // The counter holds the number of high cycles left including the current
    // one, so the pulse bit drops on the edge that ends the cycle where it reads 1.
    assign expire = busy_r && (cnt_r == CNT_LAST);

    always_comb begin
        q_nxt     = r_q;
        busy_nxt  = busy_r;
        cnt_nxt   = cnt_r;
        paddr_nxt = paddr_r;

        // Pulse timing runs first; a command in the same cycle is applied on
        // top so it always wins for the bit it addresses.
        if (expire) begin
            q_nxt[paddr_r] = 1'b0;
            busy_nxt       = 1'b0;
            cnt_nxt        = '0;
        end else if (busy_r) begin
            cnt_nxt = cnt_r - CNT_LAST;
        end

        if (cmd_vld) begin
            case (cmd_mode)
                MODE_LATCH: begin
                    // Writing over the pulsing bit hands it back to plain latch control.
                    if (busy_r && (cmd_a == paddr_r)) begin
                        busy_nxt = 1'b0;
                        cnt_nxt  = '0;
                    end
                    q_nxt[cmd_a] = cmd_dat;
                end
                MODE_DEMUX: begin
                    q_nxt        = '0;
                    q_nxt[cmd_a] = cmd_dat;
                    busy_nxt     = 1'b0;
                    cnt_nxt      = '0;
                end
                MODE_PULSE: begin
                    // A new pulse elsewhere terminates the old one early; the
                    // same address simply retriggers with a full count.
                    if (busy_r && (cmd_a != paddr_r)) begin
                        q_nxt[paddr_r] = 1'b0;
                    end
                    q_nxt[cmd_a] = 1'b1;
                    cnt_nxt      = PULSE_INIT;
                    busy_nxt     = 1'b1;
                    paddr_nxt    = cmd_a;
                end
                MODE_CLEAR: begin
                    q_nxt    = '0;
                    busy_nxt = 1'b0;
                    cnt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q     <= '0;
            busy_r  <= 1'b0;
            cnt_r   <= '0;
            paddr_r <= '0;
        end else begin
            r_q     <= q_nxt;
            busy_r  <= busy_nxt;
            cnt_r   <= cnt_nxt;
            paddr_r <= paddr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: oe only gates the pins, never the stored state.
    // ------------------------------------------------------------------
    assign q    = oe ? {WIDTH{1'bz}} : r_q;
    assign busy = busy_r;

endmodule

// File: tb/tb_mc_addr_latch.sv
// Purpose : directed self-checking bench for mc_addr_latch (default build, 1-cycle strobe latency).
// Latency : model runs on the same clock edges; outputs compared on every falling edge.
// Backpressure: n/a.
module tb_mc_addr_latch;

    localparam int AW = 3;
    localparam int W  = 8;
    localparam int L  = 4;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          dat  = 1'b0;
    logic          stb  = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic [AW-1:0] a    = '0;
    logic          oe   = 1'b0;
    wire  [W-1:0]  q;
    logic          busy;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mc_addr_latch #(
        .AW        (AW),
        .PULSE_LEN (L),
        .CW        (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .dat  (dat),
        .stb  (stb),
        .mode (mode),
        .a    (a),
        .oe   (oe),
        .q    (q),
        .busy (busy)
    );

    // ------------------------------------------------------------------
    // Model: pulses are tracked by the absolute cycle at which they end.
    // ------------------------------------------------------------------
    logic [W-1:0] mq      = '0;
    bit           m_pulse = 1'b0;
    int           m_bit   = 0;
    int           m_end   = 0;
    int           m_cyc   = 0;
    bit           m_prev  = 1'b1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq      = '0;
            m_pulse = 1'b0;
            m_bit   = 0;
            m_prev  = 1'b1;
            m_cyc   = 0;
        end else begin
            m_cyc++;
            if (m_pulse && m_cyc == m_end) begin
                mq[m_bit] = 1'b0;
                m_pulse   = 1'b0;
            end
            if (stb && !m_prev) begin
                case (mode)
                    2'd0: begin
                        if (m_pulse && int'(a) == m_bit) m_pulse = 1'b0;
                        mq[a] = dat;
                    end
                    2'd1: begin
                        mq      = '0;
                        mq[a]   = dat;
                        m_pulse = 1'b0;
                    end
                    2'd2: begin
                        if (m_pulse && int'(a) != m_bit) mq[m_bit] = 1'b0;
                        mq[a]   = 1'b1;
                        m_pulse = 1'b1;
                        m_bit   = int'(a);
                        m_end   = m_cyc + L;
                    end
                    default: begin
                        mq      = '0;
                        m_pulse = 1'b0;
                    end
                endcase
            end
            m_prev = stb;
        end
    end

    // Per-cycle comparison against the model (q only while driven).
    always @(negedge clk) begin
        if (chk_en) begin
            if (!oe) begin
                total++;
                if (q !== mq) begin
                    bad++;
                    $display("FAIL cyc_q t=%0t q=%h expected=%h", $time, q, mq);
                end
            end
            total++;
            if (busy !== m_pulse) begin
                bad++;
                $display("FAIL cyc_busy t=%0t busy=%b expected=%b", $time, busy, m_pulse);
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [W-1:0] eq, input logic eb);
        total++;
        if (q !== eq || busy !== eb) begin
            bad++;
            $display("FAIL %s q=%h busy=%b expected q=%h busy=%b", nm, q, busy, eq, eb);
        end
    endtask

    // While oe=1 the pins must not present the stored value.
    task automatic hidden(input string nm, input logic [W-1:0] stored);
        total++;
        if (q === stored) begin
            bad++;
            $display("FAIL %s q=%h still shows stored value with oe=1", nm, q);
        end
    endtask

    task automatic wr(input logic [1:0] m, input int ad, input logic d);
        stb  = 1'b1;
        mode = m;
        a    = ad[AW-1:0];
        dat  = d;
        step(1);
        stb  = 1'b0;
        step(1);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        #1 rst = 1'b0;
        #1 lit("reset", 8'h00, 1'b0);
        step(2);
        rst    = 1'b1;
        chk_en = 1'b1;
        step(3);
        lit("no_write_stb_held", 8'h00, 1'b0);

        // First real edge: LATCH a=5
        stb = 1'b0;
        step(1);
        stb = 1'b1; mode = 2'd0; a = 3'd5; dat = 1'b1;
        step(1);
        lit("latch_a5", 8'h20, 1'b0);
        stb = 1'b0;
        step(1);

        for (int i = 0; i < W; i++) wr(2'd0, i, 1'b1);
        lit("all_ones", 8'hFF, 1'b0);
        wr(2'd1, 2, 1'b1);
        lit("demux_a2", 8'h04, 1'b0);
        wr(2'd3, 5, 1'b1);
        lit("clear", 8'h00, 1'b0);

        // Level held 10 cycles: only the first cycle's fields may land.
        stb = 1'b1; mode = 2'd0; a = 3'd0; dat = 1'b1;
        step(1);
        dat = 1'b0; a = 3'd1;
        step(9);
        lit("held_single_write", 8'h01, 1'b0);
        stb = 1'b0;
        step(1);
        wr(2'd3, 0, 1'b0);

        // Plain pulse on bit 3
        stb = 1'b1; mode = 2'd2; a = 3'd3; dat = 1'b0;
        step(1);
        lit("pulse_first", 8'h08, 1'b1);
        stb = 1'b0;
        step(3);
        lit("pulse_fourth", 8'h08, 1'b1);
        step(1);
        lit("pulse_done", 8'h00, 1'b0);
        step(2);

        // Pulse 3 then pulse 6 two cycles later
        stb = 1'b1; mode = 2'd2; a = 3'd3;
        step(1);
        stb = 1'b0;
        step(1);
        stb = 1'b1; a = 3'd6;
        step(1);
        lit("pulse_move", 8'h40, 1'b1);
        stb = 1'b0;
        step(3);
        lit("pulse_move_last", 8'h40, 1'b1);
        step(1);
        lit("pulse_move_done", 8'h00, 1'b0);
        step(2);

        // Retrigger bit 3 while its count is 2
        stb = 1'b1; mode = 2'd2; a = 3'd3;
        step(1);
        stb = 1'b0;
        step(2);
        stb = 1'b1;
        step(1);
        stb = 1'b0;
        step(3);
        lit("retrig_last", 8'h08, 1'b1);
        step(1);
        lit("retrig_done", 8'h00, 1'b0);
        step(2);

        // LATCH onto the pulsing bit cancels the pulse
        stb = 1'b1; mode = 2'd2; a = 3'd1;
        step(1);
        stb = 1'b0;
        step(1);
        wr(2'd0, 1, 1'b1);
        step(10);
        lit("latch_cancels", 8'h02, 1'b0);
        wr(2'd3, 0, 1'b0);

        // CLEAR during a pulse
        wr(2'd2, 1, 1'b0);
        wr(2'd3, 0, 1'b0);
        lit("clear_cancels", 8'h00, 1'b0);

        // Expiry coinciding with a LATCH elsewhere
        stb = 1'b1; mode = 2'd2; a = 3'd2;
        step(1);
        stb = 1'b0;
        step(3);
        stb = 1'b1; mode = 2'd0; a = 3'd5; dat = 1'b1;
        step(1);
        lit("expire_collide", 8'h20, 1'b0);
        stb = 1'b0;
        step(1);

        // Output enable gating
        oe = 1'b1;
        #1 hidden("oe_hidden", 8'h20);
        wr(2'd0, 7, 1'b1);
        hidden("oe_hidden_write", 8'hA0);
        oe = 1'b0;
        #1 lit("oe_restored", 8'hA0, 1'b0);

        // Asynchronous reset in the middle of a pulse
        wr(2'd2, 4, 1'b0);
        lit("pre_reset_pulse", 8'hB0, 1'b1);
        #2 rst = 1'b0;
        #1 lit("async_reset", 8'h00, 1'b0);
        step(2);
        rst = 1'b1;
        step(3);
        lit("after_reset", 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_addr_latch.md
Name: mc_addr_latch

Overview:
- Clocked, parametrised addressable output latch for the MC14500B companion set.
- Generalises the 8-bit addressable latch to 2**AW outputs, and adds four write modes, including a self-timed one-shot pulse mode.
- Sits on the ICU data/write strobe and drives a tri-stated output port.
- Write commands are taken on the rising edge of the strobe, sampled in the clk domain.

Parameters:
- AW, 3, address width; output width WIDTH = 2**AW (derived localparam, not overridable).
- PULSE_LEN, 4, cycles a PULSE-mode bit stays high; legal range 1..2**CW-1.
- CW, 8, pulse counter width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- dat  in  1  data bit to write.
- stb  in  1  write strobe; a command is taken on its rising edge.
- mode  in  2  write mode, sampled with stb.
- a  in  AW  bit address.
- oe  in  1  active-low output enable.
- q  out  WIDTH  latched outputs; high-Z when oe=1.
- busy  out  1  pulse in progress; never tri-stated.

Behaviour:
- Reset (rst=0, async):
  - r_q=0, busy=0, counter=0, pulse address=0.
  - The strobe-history flop resets to 1, so a strobe held high through reset release does not trigger a write.
- Strobe detection:
  - The edge is stb=1 while the history flop is 0.
  - dat, mode and a are captured in the same cycle as the edge.
  - The effect is visible on q in the cycle after the edge (1-cycle latency).
  - A level held high produces exactly one command.
- q = r_q when oe=0, else 'z. oe does not affect internal state.
- MODE_LATCH (00): r_q[a] <= dat; other bits hold.
- MODE_DEMUX (01): r_q <= 0 except r_q[a] <= dat.
- MODE_PULSE (10):
  - r_q[a] <= 1, counter <= PULSE_LEN, busy <= 1, pulse address <= a. dat is ignored.
  - While busy, the counter decrements each cycle.
  - In the cycle the counter reaches 1, the next edge sets r_q[pulse address] <= 0, busy <= 0 and counter <= 0.
  - Result: the bit is high for exactly PULSE_LEN cycles.
- MODE_CLEAR (11): r_q <= 0; dat and a are ignored.
- Collisions:
  - PULSE while busy, different address: the old pulse bit clears immediately and the new pulse starts with a full count.
  - PULSE while busy, same address: the bit stays high and the count reloads (retrigger).
  - LATCH to the pulse address while busy: the pulse is cancelled (busy=0 next cycle) and dat stands.
  - LATCH to another address while busy: applied; the pulse continues.
  - DEMUX or CLEAR while busy: the pulse is cancelled and busy=0.
  - Pulse expiry in the same cycle as a new command: the command wins for its addressed bit; expiry still clears the pulse bit if the addresses differ.
- Mode encoding: all four 2-bit values are defined; there are no illegal modes.
- Mid-operation reset: asynchronous clear of everything, including an active pulse.

Optional Feature:
- Macro: MC_ADDR_LATCH_SYNC_EN.
- Defined: stb passes through a 2-flop synchroniser (reset value 0 in both flops) before edge detection.
  - dat, mode and a are delayed through matching registers.
  - Latency from stb rising to q becomes 3 cycles.
- Undefined: stb is used directly, with 1-cycle latency. The caller guarantees stb is synchronous to clk.

Decomposition:
- Package mc_latch_pkg:
  - MODE_LATCH=2'b00, MODE_DEMUX=2'b01, MODE_PULSE=2'b10, MODE_CLEAR=2'b11.
  - Typedef mc_mode_t.
- Sub-module mc_edge_det: optional synchroniser, history flop (reset 1) and rising-edge pulse output. It is reusable by other companion chips.

Test Plan:
- Reset with stb held 1, then release: no write; q=8'h00, busy=0. Drop stb, raise it with LATCH, a=5, dat=1: q=8'h20 one cycle after the edge.
- q=8'hFF via LATCH writes, then DEMUX with a=2, dat=1: q=8'h04. Then CLEAR: q=8'h00. Hold stb high 10 cycles: exactly one write.
- PULSE a=3, PULSE_LEN=4: q[3]=1 and busy=1 for exactly 4 cycles, then q=8'h00, busy=0.
- PULSE a=3, then PULSE a=6 two cycles later: q[3] clears at once; q[6] is high for 4 cycles. Separately, re-PULSE a=3 at count 2: q[3] stays high for 4 more cycles.
- PULSE a=1, then LATCH a=1, dat=1 mid-pulse: busy drops next cycle and q[1] stays 1 indefinitely. Separately, with a pulse on a=1 active, CLEAR: q=0, busy=0.
- oe=1: q reads all 'z while writes still update state; oe=0 shows the updated value. Assert rst mid-pulse: q=0 and busy=0 immediately (async).
